lru_alloc: RTL and testbench

LRU_ALLOC -- requirements
Module: lru_alloc

---
 rtl/lru_alloc.sv | 160 ++++++++++++++++
 tb/tb_lru_alloc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_alloc.sv
// lru_alloc: true-LRU rank tracker with a single-entry victim allocator.
// Each entry carries a rank (0 = most recently used, LENGTH-1 = least
// recently used) that always forms a permutation, plus a valid bit.
// Victims are offered through a valid/yumi handshake with one cycle of latency.
module lru_alloc #(
    parameter int LENGTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      touch_i,
    input  logic [$clog2(LENGTH)-1:0] touch_idx_i,
    input  logic                      inv_i,
    input  logic [$clog2(LENGTH)-1:0] inv_idx_i,
    input  logic                      alloc_req_i,
    output logic                      alloc_v_o,
    output logic [$clog2(LENGTH)-1:0] alloc_idx_o,
    input  logic                      alloc_yumi_i,
    output logic [$clog2(LENGTH)-1:0] lru_idx_o,
    output logic                      full_o
);

    localparam int W = $clog2(LENGTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]        state_q;
    logic [W-1:0]      rank_q [LENGTH];
    logic [W-1:0]      rank_d [LENGTH];
    logic [LENGTH-1:0] valid_q;
    logic [LENGTH-1:0] valid_d;
    logic [W-1:0]      alloc_idx_q;

    logic              commit;
    logic              upd_en;
    logic              upd_promote;
    logic [W-1:0]      upd_idx;
    logic [W-1:0]      upd_rank;
    logic [W-1:0]      lru_idx;
    logic [W-1:0]      victim_idx;
    logic              victim_found;

    // A commit only counts when no invalidate claims the rank update this cycle;
    // a pre-empted commit leaves the offer standing.
    assign commit = (state_q == OFFER) && alloc_yumi_i && !inv_i;

    assign alloc_v_o   = (state_q == OFFER);
    assign alloc_idx_o = alloc_idx_q;
    assign lru_idx_o   = lru_idx;
    assign full_o      = &valid_q;

    // Locate the entry holding the oldest rank.
    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (rank_q[i] == W'(LENGTH - 1)) begin
                lru_idx = W'(i);
            end
        end
    end

    // Prefer the lowest-numbered free entry; fall back to the LRU entry when full.
    always_comb begin
        victim_idx   = lru_idx;
        victim_found = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            if (!victim_found && !valid_q[i]) begin
                victim_idx   = W'(i);
                victim_found = 1'b1;
            end
        end
    end

    // Pick the single rank operation for this cycle: invalidate, then commit, then touch.
    always_comb begin
        upd_en      = 1'b0;
        upd_promote = 1'b0;
        upd_idx     = '0;
        if (inv_i) begin
            upd_en      = 1'b1;
            upd_promote = 1'b0;
            upd_idx     = inv_idx_i;
        end else if (commit) begin
            upd_en      = 1'b1;
            upd_promote = 1'b1;
            upd_idx     = alloc_idx_q;
        end else if (touch_i) begin
            upd_en      = 1'b1;
            upd_promote = 1'b1;
            upd_idx     = touch_idx_i;
        end
        upd_rank = rank_q[upd_idx];
    end

    // Apply the chosen promote/demote to every entry's rank and valid bit.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < LENGTH; i++) begin
            rank_d[i] = rank_q[i];
            if (upd_en) begin
                if (upd_idx == W'(i)) begin
                    if (upd_promote) begin
                        rank_d[i] = '0;
                        if (commit) begin
                            valid_d[i] = 1'b1;
                        end
                    end else begin
                        rank_d[i]  = W'(LENGTH - 1);
                        valid_d[i] = 1'b0;
                    end
                end else if (upd_promote && (rank_q[i] < upd_rank)) begin
                    rank_d[i] = rank_q[i] + W'(1);
                end else if (!upd_promote && (rank_q[i] > upd_rank)) begin
                    rank_d[i] = rank_q[i] - W'(1);
                end
            end
        end
    end

    // Rank and valid state registers; reset restores the identity ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                rank_q[i] <= W'(i);
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                rank_q[i] <= rank_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // Offer handshake: capture the victim on entry to OFFER and hold it until committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alloc_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alloc_req_i) begin
                        state_q     <= OFFER;
                        alloc_idx_q <= victim_idx;
                    end
                end
                OFFER: begin
                    if (commit) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lru_alloc.sv
// tb_lru_alloc: directed scenario tests for lru_alloc with LENGTH=8.
module tb_lru_alloc;

    logic       clk;
    logic       rst;
    logic       touch_i;
    logic [2:0] touch_idx_i;
    logic       inv_i;
    logic [2:0] inv_idx_i;
    logic       alloc_req_i;
    logic       alloc_v_o;
    logic [2:0] alloc_idx_o;
    logic       alloc_yumi_i;
    logic [2:0] lru_idx_o;
    logic       full_o;

    int checks = 0;
    int errors = 0;

    lru_alloc #(.LENGTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .touch_i      (touch_i),
        .touch_idx_i  (touch_idx_i),
        .inv_i        (inv_i),
        .inv_idx_i    (inv_idx_i),
        .alloc_req_i  (alloc_req_i),
        .alloc_v_o    (alloc_v_o),
        .alloc_idx_o  (alloc_idx_o),
        .alloc_yumi_i (alloc_yumi_i),
        .lru_idx_o    (lru_idx_o),
        .full_o       (full_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        touch_i      = 1'b0;
        touch_idx_i  = 3'd0;
        inv_i        = 1'b0;
        inv_idx_i    = 3'd0;
        alloc_req_i  = 1'b0;
        alloc_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd7) begin errors++; $display("[TB] FAIL reset_lru got %0d want 7", lru_idx_o); end
        checks++;
        if (full_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", full_o); end
        checks++;
        if (alloc_v_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_v got %0b want 0", alloc_v_o); end
        checks++;
        if (alloc_idx_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", alloc_idx_o); end
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd0) begin
            errors++; $display("[TB] FAIL first_offer got v=%0b idx=%0d want v=1 idx=0", alloc_v_o, alloc_idx_o);
        end
        // A request during OFFER must not move the offered index.
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd0) begin
            errors++; $display("[TB] FAIL offer_stable got v=%0b idx=%0d want v=1 idx=0", alloc_v_o, alloc_idx_o);
        end
    endtask

    task automatic test_fill();
        alloc_yumi_i = 1'b1;
        tick();
        alloc_yumi_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b0) begin errors++; $display("[TB] FAIL commit0_v got %0b want 0", alloc_v_o); end
        for (int k = 1; k < 8; k++) begin
            alloc_req_i = 1'b1;
            tick();
            alloc_req_i = 1'b0;
            checks++;
            if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'(k)) begin
                errors++; $display("[TB] FAIL fill_offer got v=%0b idx=%0d want v=1 idx=%0d", alloc_v_o, alloc_idx_o, k);
            end
            alloc_yumi_i = 1'b1;
            tick();
            alloc_yumi_i = 1'b0;
        end
        checks++;
        if (full_o !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %0b want 1", full_o); end
        checks++;
        if (lru_idx_o !== 3'd0) begin errors++; $display("[TB] FAIL fill_lru got %0d want 0", lru_idx_o); end
    endtask

    task automatic test_touch();
        touch_i = 1'b1; touch_idx_i = 3'd0;
        tick();
        touch_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd1) begin errors++; $display("[TB] FAIL touch_lru got %0d want 1", lru_idx_o); end
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd1) begin
            errors++; $display("[TB] FAIL full_victim got v=%0b idx=%0d want v=1 idx=1", alloc_v_o, alloc_idx_o);
        end
        alloc_yumi_i = 1'b1;
        tick();
        alloc_yumi_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd2 || full_o !== 1'b1) begin
            errors++; $display("[TB] FAIL touch_commit got lru=%0d full=%0b want lru=2 full=1", lru_idx_o, full_o);
        end
    endtask

    task automatic test_invalidate();
        inv_i = 1'b1; inv_idx_i = 3'd5;
        tick();
        inv_i = 1'b0;
        checks++;
        if (full_o !== 1'b0 || lru_idx_o !== 3'd5) begin
            errors++; $display("[TB] FAIL inv_state got full=%0b lru=%0d want full=0 lru=5", full_o, lru_idx_o);
        end
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd5) begin
            errors++; $display("[TB] FAIL inv_victim got v=%0b idx=%0d want v=1 idx=5", alloc_v_o, alloc_idx_o);
        end
        alloc_yumi_i = 1'b1;
        tick();
        alloc_yumi_i = 1'b0;
        checks++;
        if (full_o !== 1'b1 || lru_idx_o !== 3'd2) begin
            errors++; $display("[TB] FAIL inv_commit got full=%0b lru=%0d want full=1 lru=2", full_o, lru_idx_o);
        end
    endtask

    task automatic test_priority();
        inv_i = 1'b1; inv_idx_i = 3'd3;
        touch_i = 1'b1; touch_idx_i = 3'd3;
        tick();
        inv_i = 1'b0; touch_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd3 || full_o !== 1'b0) begin
            errors++; $display("[TB] FAIL inv_over_touch got lru=%0d full=%0b want lru=3 full=0", lru_idx_o, full_o);
        end
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd3) begin
            errors++; $display("[TB] FAIL prio_offer got v=%0b idx=%0d want v=1 idx=3", alloc_v_o, alloc_idx_o);
        end
        alloc_yumi_i = 1'b1; touch_i = 1'b1; touch_idx_i = 3'd6;
        tick();
        alloc_yumi_i = 1'b0; touch_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b0 || full_o !== 1'b1 || lru_idx_o !== 3'd2) begin
            errors++; $display("[TB] FAIL commit_over_touch got v=%0b full=%0b lru=%0d want v=0 full=1 lru=2", alloc_v_o, full_o, lru_idx_o);
        end
        // Follow-up touches expose whether the dropped touch of 6 leaked into the ranks.
        touch_i = 1'b1; touch_idx_i = 3'd2;
        tick();
        checks++;
        if (lru_idx_o !== 3'd4) begin errors++; $display("[TB] FAIL probe_touch2 got lru=%0d want 4", lru_idx_o); end
        touch_idx_i = 3'd4;
        tick();
        checks++;
        if (lru_idx_o !== 3'd6) begin errors++; $display("[TB] FAIL probe_touch4 got lru=%0d want 6", lru_idx_o); end
        tick();
        touch_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd6) begin errors++; $display("[TB] FAIL mru_touch got lru=%0d want 6", lru_idx_o); end
    endtask

    task automatic test_reset_mid_offer();
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd6) begin
            errors++; $display("[TB] FAIL pre_reset_offer got v=%0b idx=%0d want v=1 idx=6", alloc_v_o, alloc_idx_o);
        end
        rst = 1'b1; alloc_yumi_i = 1'b1;
        tick();
        rst = 1'b0; alloc_yumi_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b0 || full_o !== 1'b0 || lru_idx_o !== 3'd7 || alloc_idx_o !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_mid_offer got v=%0b full=%0b lru=%0d idx=%0d want v=0 full=0 lru=7 idx=0",
                               alloc_v_o, full_o, lru_idx_o, alloc_idx_o);
        end
    endtask

    task automatic test_corner_cases();
        // Yumi with no offer outstanding does nothing.
        alloc_yumi_i = 1'b1;
        tick();
        alloc_yumi_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b0 || full_o !== 1'b0 || lru_idx_o !== 3'd7) begin
            errors++; $display("[TB] FAIL stray_yumi got v=%0b full=%0b lru=%0d want v=0 full=0 lru=7", alloc_v_o, full_o, lru_idx_o);
        end
        // Touching an invalid entry promotes it but leaves it invalid.
        touch_i = 1'b1; touch_idx_i = 3'd7;
        tick();
        touch_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd6 || full_o !== 1'b0) begin
            errors++; $display("[TB] FAIL touch_invalid got lru=%0d full=%0b want lru=6 full=0", lru_idx_o, full_o);
        end
        // Invalidating an already invalid entry still demotes it.
        inv_i = 1'b1; inv_idx_i = 3'd7;
        tick();
        inv_i = 1'b0;
        checks++;
        if (lru_idx_o !== 3'd7) begin errors++; $display("[TB] FAIL inv_invalid got lru=%0d want 7", lru_idx_o); end
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd0) begin
            errors++; $display("[TB] FAIL post_reset_victim got v=%0b idx=%0d want v=1 idx=0", alloc_v_o, alloc_idx_o);
        end
        // Invalidating the offered entry keeps the offer alive; commit re-validates it.
        inv_i = 1'b1; inv_idx_i = 3'd0;
        tick();
        inv_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd0 || lru_idx_o !== 3'd0) begin
            errors++; $display("[TB] FAIL inv_offered got v=%0b idx=%0d lru=%0d want v=1 idx=0 lru=0", alloc_v_o, alloc_idx_o, lru_idx_o);
        end
        alloc_yumi_i = 1'b1;
        tick();
        alloc_yumi_i = 1'b0;
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++;
        if (alloc_v_o !== 1'b1 || alloc_idx_o !== 3'd1 || lru_idx_o !== 3'd7) begin
            errors++; $display("[TB] FAIL revalidate got v=%0b idx=%0d lru=%0d want v=1 idx=1 lru=7", alloc_v_o, alloc_idx_o, lru_idx_o);
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        test_reset();
        test_fill();
        test_touch();
        test_invalidate();
        test_priority();
        test_reset_mid_offer();
        test_corner_cases();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
